// File: rtl/noc_router_output_arbiter.sv
// ============================================================================
//  Module   : noc_router_output_arbiter
//  Purpose  : Packet-granular round-robin arbiter for one router output port,
//             driving a one-deep registered output stage toward the link.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module noc_router_output_arbiter #(
    parameter int FLIT_WIDTH = 32,
    parameter int INPUTS     = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0]            in_valid,
    output logic [INPUTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int c_PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic [c_PTR_W-1:0]   r_grant;
    logic [c_PTR_W-1:0]   w_grant_nxt;

    logic [FLIT_WIDTH-1:0] r_out_flit;
    logic                  r_out_last;
    logic                  r_out_valid;

    logic                  w_space;
    logic                  w_found;
    logic [c_PTR_W-1:0]    w_sel;
    logic [INPUTS-1:0]     w_ready;
    logic                  w_load;
    logic [c_PTR_W-1:0]    w_load_idx;
    logic [FLIT_WIDTH-1:0] w_mux_flit;
    logic                  w_mux_last;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(INPUTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_space = !r_out_valid || out_ready;

    // Rotating priority search starting at r_ptr, wrapping past INPUTS-1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < INPUTS; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= INPUTS) idx = idx - INPUTS;
            if (!w_found && in_valid[idx]) begin
                w_found = 1'b1;
                w_sel   = c_PTR_W'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_ready     = '0;
        w_load      = 1'b0;
        w_load_idx  = w_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_found && w_space) begin
                    w_ready[w_sel] = 1'b1;
                    w_load         = 1'b1;
                    if (in_last[w_sel]) begin
                        w_ptr_nxt = f_next_ptr(w_sel);
                    end else begin
                        w_grant_nxt = w_sel;
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // A bubble on the granted input simply stalls; others stay blocked.
                w_load_idx = r_grant;
                if (in_valid[r_grant] && w_space) begin
                    w_ready[r_grant] = 1'b1;
                    w_load           = 1'b1;
                    if (in_last[r_grant]) begin
                        w_ptr_nxt   = f_next_ptr(r_grant);
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mux_flit = '0;
        w_mux_last = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (w_load_idx == c_PTR_W'(i)) begin
                w_mux_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                w_mux_last = in_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // A load in the same cycle as a drain overwrites the old flit, keeping valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_flit  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_flit  <= w_mux_flit;
            r_out_last  <= w_mux_last;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = rst ? w_ready : '0;
    assign out_flit  = r_out_flit;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_noc_router_output_arbiter.sv
// ============================================================================
//  Module   : tb_noc_router_output_arbiter
//  Purpose  : Directed-vector bench for noc_router_output_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_noc_router_output_arbiter;

    localparam int FLIT_WIDTH = 32;
    localparam int INPUTS     = 7;

    logic                         clk;
    logic                         rst;
    logic [INPUTS*FLIT_WIDTH-1:0] in_flit;
    logic [INPUTS-1:0]            in_last;
    logic [INPUTS-1:0]            in_valid;
    logic [INPUTS-1:0]            in_ready;
    logic [FLIT_WIDTH-1:0]        out_flit;
    logic                         out_last;
    logic                         out_valid;
    logic                         out_ready;

    int unsigned cnt [INPUTS];
    int          n_vec;
    int          n_err;

    noc_router_output_arbiter #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .INPUTS     (INPUTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flit payload encodes source input and per-input sequence number.
    function automatic logic [31:0] fv(input int i, input int unsigned n);
        logic [31:0] iv;
        logic [31:0] nv;
        iv = 32'(i);
        nv = 32'(n);
        return {4'hA, iv[3:0], nv[23:0]};
    endfunction

    always_comb begin
        in_flit = '0;
        for (int i = 0; i < INPUTS; i++) begin
            in_flit[i*FLIT_WIDTH +: FLIT_WIDTH] = fv(i, cnt[i]);
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = '0;
        in_last  = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic expect_accept(input string tag, input int idx, input logic last);
        #1;
        check_vec({tag, "_rdy"}, 32'(in_ready), 32'(1) << idx);
        step();
        check_vec({tag, "_flit"}, out_flit, fv(idx, cnt[idx]));
        check_vec({tag, "_last"}, 32'(out_last), 32'(last));
        check_vec({tag, "_vld"}, 32'(out_valid), 32'd1);
        cnt[idx]++;
    endtask

    initial begin
        int order [6];
        order     = '{0, 2, 5, 0, 2, 5};
        n_vec     = 0;
        n_err     = 0;
        for (int i = 0; i < INPUTS; i++) cnt[i] = 0;
        rst       = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;

        // Reset holds everything quiet even with every input requesting.
        in_valid = '1;
        in_last  = '1;
        step();
        step();
        #1;
        check_vec("rst_rdy",  32'(in_ready),  32'd0);
        check_vec("rst_vld",  32'(out_valid), 32'd0);
        check_vec("rst_flit", out_flit,       32'd0);
        rst = 1'b1;
        expect_accept("rel0", 0, 1'b1);
        expect_accept("rel1", 1, 1'b1);
        in_valid = '0;

        // Round-robin over single-flit packets, one per cycle.
        do_reset();
        in_last  = '1;
        in_valid = 7'b0100101;
        for (int k = 0; k < 6; k++) expect_accept("rr", order[k], 1'b1);
        in_valid = '0;
        step();
        check_vec("rr_drain", 32'(out_valid), 32'd0);

        // Four-flit packet on input 1 is not interleaved with input 3.
        do_reset();
        in_valid = 7'b0001010;
        in_last  = 7'b0001000;
        for (int k = 0; k < 4; k++) begin
            in_last[1] = (k == 3);
            expect_accept("lock", 1, k == 3);
        end
        in_valid[1] = 1'b0;
        expect_accept("lock_next", 3, 1'b1);
        in_valid = '0;

        // Backpressure: output held, nothing accepted, then resumes in order.
        do_reset();
        in_valid = 7'b0000100;
        in_last  = '0;
        expect_accept("bp_first", 2, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_vec("bp_rdy", 32'(in_ready), 32'd0);
            step();
            check_vec("bp_hold", out_flit, fv(2, cnt[2] - 1));
            check_vec("bp_vld", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        expect_accept("bp_resume", 2, 1'b0);
        in_last[2] = 1'b1;
        expect_accept("bp_last", 2, 1'b1);
        in_valid = '0;
        step();
        check_vec("bp_drain", 32'(out_valid), 32'd0);

        // Bubble on granted input 4 keeps input 0 blocked.
        do_reset();
        in_valid = 7'b0010000;
        in_last  = '0;
        expect_accept("bub_first", 4, 1'b0);
        in_valid = 7'b0000001;
        in_last  = 7'b0000001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_vec("bub_rdy", 32'(in_ready), 32'd0);
            step();
            check_vec("bub_vld", 32'(out_valid), 32'd0);
        end
        in_valid = 7'b0010001;
        in_last  = 7'b0010001;
        expect_accept("bub_last", 4, 1'b1);
        in_valid[4] = 1'b0;
        expect_accept("bub_next", 0, 1'b1);
        in_valid = '0;

        // Asynchronous reset mid-packet; arbitration restarts from input 0.
        do_reset();
        in_valid = 7'b0100000;
        in_last  = '1;
        expect_accept("ar_pre", 5, 1'b1);
        in_valid = 7'b0001000;
        in_last  = '0;
        expect_accept("ar_f0", 3, 1'b0);
        expect_accept("ar_f1", 3, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check_vec("ar_vld", 32'(out_valid), 32'd0);
        check_vec("ar_rdy", 32'(in_ready),  32'd0);
        in_valid = '0;
        step();
        rst      = 1'b1;
        in_valid = 7'b1000010;
        in_last  = '1;
        expect_accept("ar_fresh1", 1, 1'b1);
        expect_accept("ar_fresh6", 6, 1'b1);
        in_valid = 7'b0000011;
        expect_accept("ar_wrap0", 0, 1'b1);
        in_valid = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
